// File: rtl/conv_mac_sequencer.sv
// Beat sequencer for the multiply array: walks pixel-group x channel-group loops,
// handshakes with the feature buffer and delays accumulator tags by the multiplier latency.
module conv_mac_sequencer #(
  parameter int unsigned KERNEL_NUM   = 1,
  parameter int unsigned MULT_LATENCY = 3,
  parameter int unsigned CH_W         = 10,
  parameter int unsigned PIX_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CH_W-1:0]   cfg_ch_grp,
  input  logic [PIX_W-1:0]  cfg_pix_grp,
  output logic              busy,
  output logic              done,
  output logic              data_req,
  input  logic              data_rdy,
  output logic [CH_W+3:0]   wt_addr,
  output logic              acc_en,
  output logic              acc_first,
  output logic              acc_last,
  output logic [PIX_W-1:0]  out_pix
);

  localparam int unsigned AW    = CH_W + 4;
  localparam int unsigned CNT_W = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CH_W-1:0]  n_q, n_d, ch_q, ch_d;
  logic [PIX_W-1:0] p_q, p_d, pix_q, pix_d;
  logic [AW-1:0]    wt_q, wt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_d;
  logic             fire, ch_wrap, last_beat;

  logic [MULT_LATENCY-1:0] tag_v, tag_f, tag_l;
  logic [PIX_W-1:0]        tag_p [MULT_LATENCY];

  assign fire      = (state_q == RUN) && data_rdy;
  assign ch_wrap   = (ch_q == n_q - CH_W'(1));
  assign last_beat = ch_wrap && (pix_q == p_q - PIX_W'(1));

  // Next-state, loop counters and weight address (kept as ch_idx * KERNEL_NUM by stride adds)
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    p_d     = p_q;
    ch_d    = ch_q;
    pix_d   = pix_q;
    wt_d    = wt_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ch_grp == '0 || cfg_pix_grp == '0) begin
            done_d = 1'b1;
          end else begin
            n_d     = cfg_ch_grp;
            p_d     = cfg_pix_grp;
            ch_d    = '0;
            pix_d   = '0;
            wt_d    = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (fire) begin
          if (ch_wrap) begin
            ch_d  = '0;
            wt_d  = '0;
            pix_d = last_beat ? '0 : pix_q + PIX_W'(1);
          end else begin
            ch_d = ch_q + CH_W'(1);
            wt_d = wt_q + AW'(KERNEL_NUM);
          end
          if (last_beat) begin
            state_d = DRAIN;
            cnt_d   = CNT_W'(MULT_LATENCY - 1);
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      p_q      <= '0;
      ch_q     <= '0;
      pix_q    <= '0;
      wt_q     <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_req <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      p_q      <= p_d;
      ch_q     <= ch_d;
      pix_q    <= pix_d;
      wt_q     <= wt_d;
      cnt_q    <= cnt_d;
      busy     <= (state_d != IDLE);
      done     <= done_d;
      data_req <= (state_d == RUN);
    end
  end

  // Tag delay line; non-fire cycles push an all-zero bubble so outputs stay qualified
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v <= '0;
      tag_f <= '0;
      tag_l <= '0;
      for (int i = 0; i < int'(MULT_LATENCY); i++) tag_p[i] <= '0;
    end else begin
      for (int i = int'(MULT_LATENCY) - 1; i > 0; i--) begin
        tag_v[i] <= tag_v[i-1];
        tag_f[i] <= tag_f[i-1];
        tag_l[i] <= tag_l[i-1];
        tag_p[i] <= tag_p[i-1];
      end
      tag_v[0] <= fire;
      tag_f[0] <= fire && (ch_q == '0);
      tag_l[0] <= fire && ch_wrap;
      tag_p[0] <= fire ? pix_q : '0;
    end
  end

  assign wt_addr   = wt_q;
  assign acc_en    = tag_v[MULT_LATENCY-1];
  assign acc_first = tag_f[MULT_LATENCY-1];
  assign acc_last  = tag_l[MULT_LATENCY-1];
  assign out_pix   = tag_p[MULT_LATENCY-1];

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Bench for conv_mac_sequencer: two instances (KERNEL_NUM 1 and 9) driven together,
// checked every cycle against a beat-counting model plus literal timing points.
module tb_conv_mac_sequencer;

  localparam int L     = 3;
  localparam int CH_W  = 10;
  localparam int PIX_W = 16;
  localparam int AW    = CH_W + 4;

  logic clk = 1'b0;
  logic rst, start, data_rdy;
  logic [CH_W-1:0]  cfg_ch_grp;
  logic [PIX_W-1:0] cfg_pix_grp;

  logic a_busy, a_done, a_req, a_en, a_first, a_last;
  logic [AW-1:0] a_wt;
  logic [PIX_W-1:0] a_pix;
  logic b_busy, b_done, b_req, b_en, b_first, b_last;
  logic [AW-1:0] b_wt;
  logic [PIX_W-1:0] b_pix;

  conv_mac_sequencer #(.KERNEL_NUM(1), .MULT_LATENCY(L), .CH_W(CH_W), .PIX_W(PIX_W)) dut_a (
    .clk(clk), .rst(rst), .start(start), .cfg_ch_grp(cfg_ch_grp), .cfg_pix_grp(cfg_pix_grp),
    .busy(a_busy), .done(a_done), .data_req(a_req), .data_rdy(data_rdy), .wt_addr(a_wt),
    .acc_en(a_en), .acc_first(a_first), .acc_last(a_last), .out_pix(a_pix));

  conv_mac_sequencer #(.KERNEL_NUM(9), .MULT_LATENCY(L), .CH_W(CH_W), .PIX_W(PIX_W)) dut_b (
    .clk(clk), .rst(rst), .start(start), .cfg_ch_grp(cfg_ch_grp), .cfg_pix_grp(cfg_pix_grp),
    .busy(b_busy), .done(b_done), .data_req(b_req), .data_rdy(data_rdy), .wt_addr(b_wt),
    .acc_en(b_en), .acc_first(b_first), .acc_last(b_last), .out_pix(b_pix));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  // Model: counts beats; each fire b maps to ch=b%N, pix=b/N and lands on the accumulator L cycles later
  typedef struct { int at; bit first; bit last; int pix; } acc_t;
  acc_t q[$];
  bit m_busy = 0, m_req = 0;
  int done_at = -1;
  int b_idx = 0, mn = 1, mp = 1;
  int acc_seen = 0;

  always @(negedge clk) begin : model
    acc_t h;
    bit e_en, e_f, e_l, cur_busy;
    int e_pix, ch;
    e_en = 0; e_f = 0; e_l = 0; e_pix = 0;
    if (q.size() > 0 && q[0].at == cyc) begin
      h = q.pop_front();
      e_en = 1; e_f = h.first; e_l = h.last; e_pix = h.pix;
    end
    if (rst) begin
      chk("rst_a_outs", 64'({a_busy, a_done, a_req, a_en, a_first, a_last, a_pix, a_wt}), 64'd0);
      chk("rst_b_outs", 64'({b_busy, b_done, b_req, b_en, b_first, b_last, b_pix, b_wt}), 64'd0);
      q.delete();
      m_busy = 0; m_req = 0; done_at = -1;
    end else begin
      chk("a_busy", 64'(a_busy), 64'(m_busy));
      chk("b_busy", 64'(b_busy), 64'(m_busy));
      chk("a_done", 64'(a_done), 64'(done_at == cyc));
      chk("b_done", 64'(b_done), 64'(done_at == cyc));
      chk("a_data_req", 64'(a_req), 64'(m_req));
      chk("b_data_req", 64'(b_req), 64'(m_req));
      chk("a_acc", 64'({a_en, a_first, a_last, a_pix}), 64'({e_en, e_f, e_l, PIX_W'(e_pix)}));
      chk("b_acc", 64'({b_en, b_first, b_last, b_pix}), 64'({e_en, e_f, e_l, PIX_W'(e_pix)}));
      acc_seen += int'(a_en);
      cur_busy = m_busy;
      if (m_req && data_rdy) begin
        ch = b_idx % mn;
        chk("a_wt_addr", 64'(a_wt), 64'(ch));
        chk("b_wt_addr", 64'(b_wt), 64'(ch * 9));
        q.push_back('{cyc + L, ch == 0, ch == mn - 1, b_idx / mn});
        b_idx++;
        if (b_idx == mn * mp) begin
          m_req = 0;
          done_at = cyc + L + 1;
        end
      end
      if (done_at == cyc + 1) m_busy = 0;
      if (!cur_busy && start) begin
        if (cfg_ch_grp == '0 || cfg_pix_grp == '0) begin
          done_at = cyc + 1;
        end else begin
          m_busy = 1; m_req = 1; b_idx = 0;
          mn = int'(cfg_ch_grp); mp = int'(cfg_pix_grp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_layer(input int n, input int p);
    cfg_ch_grp  = CH_W'(n);
    cfg_pix_grp = PIX_W'(p);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int a0;

  initial begin
    rst = 1'b0; start = 1'b0; data_rdy = 1'b0; cfg_ch_grp = '0; cfg_pix_grp = '0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();

    // N=4 P=2, data always ready
    data_rdy = 1'b1;
    a0 = acc_seen;
    start_layer(4, 2);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      case (k)
        1:  chk("s1_busy_req_k1", 64'({a_busy, a_req}), 64'd3);
        3:  chk("s1_wt9_k3", 64'(b_wt), 64'd18);
        4:  chk("s1_first_k4", 64'({a_en, a_first, a_last}), 64'd6);
        7:  chk("s1_last_k7", 64'({a_last, a_pix}), 64'h10000);
        8:  chk("s1_first_k8", 64'(a_first), 64'd1);
        11: chk("s1_last_k11", 64'({a_last, a_pix}), 64'h10001);
        12: chk("s1_done_k12", 64'({a_done, a_busy}), 64'd2);
        default: ;
      endcase
      step();
    end
    chk("s1_acc_count", 64'(acc_seen - a0), 64'd8);

    // Same layer, data_rdy low in cycles 3..5
    a0 = acc_seen;
    start_layer(4, 2);
    for (int k = 1; k <= 17; k++) begin
      data_rdy = !(k >= 3 && k <= 5);
      @(negedge clk);
      case (k)
        7:  chk("s2_gap_k7", 64'(a_en), 64'd0);
        9:  chk("s2_resume_k9", 64'(a_en), 64'd1);
        15: chk("s2_done_k15", 64'(a_done), 64'd1);
        default: ;
      endcase
      step();
    end
    chk("s2_acc_count", 64'(acc_seen - a0), 64'd8);

    // N=1 P=3: every beat both first and last
    data_rdy = 1'b1;
    start_layer(1, 3);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      case (k)
        2: chk("s3_wt9_k2", 64'(b_wt), 64'd0);
        4: chk("s3_acc_k4", 64'({b_en, b_first, b_last, b_pix}), 64'h70000);
        6: chk("s3_acc_k6", 64'({b_en, b_first, b_last, b_pix}), 64'h70002);
        7: chk("s3_done_k7", 64'(b_done), 64'd1);
        default: ;
      endcase
      step();
    end

    // Zero channel groups: immediate done, nothing else moves
    start_layer(0, 5);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) chk("s4_done_k1", 64'({a_done, a_busy, a_req, a_en}), 64'd8);
      if (k == 2) chk("s4_done_k2", 64'(a_done), 64'd0);
      step();
    end

    // Second start mid-layer is ignored
    start_layer(4, 2);
    for (int k = 1; k <= 14; k++) begin
      if (k == 5) begin
        cfg_ch_grp = CH_W'(7); cfg_pix_grp = PIX_W'(7); start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (k == 12) chk("s5_done_k12", 64'(a_done), 64'd1);
      if (k == 11) chk("s5_last_k11", 64'({a_last, a_pix}), 64'h10001);
      step();
    end

    // Reset at cycle 6 aborts the layer silently
    a0 = acc_seen;
    start_layer(4, 2);
    for (int k = 1; k <= 16; k++) begin
      if (k == 6) rst = 1'b1;
      if (k == 7) rst = 1'b0;
      @(negedge clk);
      if (k == 6) chk("s6_rst_zero", 64'({a_busy, a_done, a_req, a_en, a_wt}), 64'd0);
      step();
    end
    chk("s6_acc_count", 64'(acc_seen - a0), 64'd2);

    // Random traffic: random configs, stalls and starts (including while busy)
    for (int k = 0; k < 1500; k++) begin
      data_rdy    = ($urandom % 4) != 0;
      start       = ($urandom % 8) == 0;
      cfg_ch_grp  = (($urandom % 10) == 0) ? '0 : CH_W'($urandom_range(1, 6));
      cfg_pix_grp = (($urandom % 10) == 0) ? '0 : PIX_W'($urandom_range(1, 4));
      step();
    end
    start = 1'b0;
    data_rdy = 1'b1;
    repeat (60) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
